// File: rtl/standard_ic.sv
// Shared codebase package: FSM state encodings and small helpers used across blocks.
package standard_ic;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } isa_state_e;

    // Index width for a bitmap of the given size; never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Index-to-one-hot decoder: exact inverse of the MSB-index encoder, with an
// in_range flag for indices that fall past the top of a non-power-of-2 bitmap.
module onehot_decode
    import standard_ic::*;
#(
    parameter int  WIDTH = 8,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] onehot,
    output logic             in_range
);

    localparam logic [IDXW:0] WIDTH_L = (IDXW + 1)'(WIDTH);

    assign in_range = ({1'b0, idx} < WIDTH_L);
    assign onehot   = in_range ? (WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/index_set_accumulator.sv
// Accumulates a stream of bit indices into a bitmap with distinct-bit count and
// sticky duplicate / out-of-range flags, then holds the result for a consumer.
module index_set_accumulator
    import standard_ic::*;
#(
    parameter int  WIDTH = 8,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDXW-1:0]  in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bitmap,
    output logic [IDXW:0]    out_count,
    output logic             out_dup,
    output logic             out_range_err
);

    isa_state_e       state_q, state_d;
    logic [WIDTH-1:0] bitmap_q, bitmap_d;
    logic [IDXW:0]    count_q, count_d;
    logic             dup_q, dup_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] beat_onehot;
    logic             beat_in_range;
    logic             accept;

    onehot_decode #(.WIDTH(WIDTH)) u_decode (
        .idx      (in_idx),
        .onehot   (beat_onehot),
        .in_range (beat_in_range)
    );

    // Handshake flags depend only on registered state and reset, never on out_ready.
    assign in_ready  = (state_q == ACCUM) && !reset;
    assign out_valid = (state_q == HOLD)  && !reset;
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d  = state_q;
        bitmap_d = bitmap_q;
        count_d  = count_q;
        dup_d    = dup_q;
        err_d    = err_q;

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (!beat_in_range) begin
                        err_d = 1'b1;
                    end else if ((bitmap_q & beat_onehot) != '0) begin
                        dup_d = 1'b1;
                    end else begin
                        bitmap_d = bitmap_q | beat_onehot;
                        count_d  = count_q + (IDXW + 1)'(1);
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = ACCUM;
                    bitmap_d = '0;
                    count_d  = '0;
                    dup_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every state bit, so a partial set
        // or an unconsumed bitmap never survives it.
        if (reset) begin
            state_q  <= ACCUM;
            bitmap_q <= '0;
            count_q  <= '0;
            dup_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating together on the edge.
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            dup_q    <= dup_d;
            err_q    <= err_d;
        end
    end

    // Outputs are the live accumulator in ACCUM and the frozen result in HOLD.
    assign out_bitmap    = bitmap_q;
    assign out_count     = count_q;
    assign out_dup       = dup_q;
    assign out_range_err = err_q;

endmodule

// File: tb/tb_index_set_accumulator.sv
// Directed bench for index_set_accumulator at WIDTH = 8 and WIDTH = 6.
module tb_index_set_accumulator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       v8, ir8, last8, ov8, ordy8, dup8, err8;
    logic [2:0] idx8;
    logic [7:0] bm8;
    logic [3:0] cnt8;

    // WIDTH = 6 instance
    logic       v6, ir6, last6, ov6, ordy6, dup6, err6;
    logic [2:0] idx6;
    logic [5:0] bm6;
    logic [3:0] cnt6;

    int tests = 0;
    int fails = 0;

    index_set_accumulator #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(ir8), .in_idx(idx8), .in_last(last8),
        .out_valid(ov8), .out_ready(ordy8), .out_bitmap(bm8), .out_count(cnt8),
        .out_dup(dup8), .out_range_err(err8)
    );

    index_set_accumulator #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(reset),
        .in_valid(v6), .in_ready(ir6), .in_idx(idx6), .in_last(last6),
        .out_valid(ov6), .out_ready(ordy6), .out_bitmap(bm6), .out_count(cnt6),
        .out_dup(dup6), .out_range_err(err6)
    );

    // Snapshot layout: {in_ready, out_valid, bitmap, count, dup, range_err}
    logic [15:0] snap8;
    logic [13:0] snap6;
    assign snap8 = {ir8, ov8, bm8, cnt8, dup8, err8};
    assign snap6 = {ir6, ov6, bm6, cnt6, dup6, err6};

    function automatic logic [15:0] exp8(input logic ir, input logic ov, input logic [7:0] bm,
                                         input logic [3:0] cnt, input logic dup, input logic err);
        return {ir, ov, bm, cnt, dup, err};
    endfunction

    function automatic logic [13:0] exp6(input logic ir, input logic ov, input logic [5:0] bm,
                                         input logic [3:0] cnt, input logic dup, input logic err);
        return {ir, ov, bm, cnt, dup, err};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input logic [2:0] i, input logic l);
        v8 = 1'b1; idx8 = i; last8 = l;
        cycle();
        v8 = 1'b0; last8 = 1'b0;
    endtask

    task automatic beat6(input logic [2:0] i, input logic l);
        v6 = 1'b1; idx6 = i; last6 = l;
        cycle();
        v6 = 1'b0; last6 = 1'b0;
    endtask

    task automatic handshake8();
        ordy8 = 1'b1;
        cycle();
        ordy8 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v8 = 1'b0; idx8 = '0; last8 = 1'b0; ordy8 = 1'b0;
        v6 = 1'b0; idx6 = '0; last6 = 1'b0; ordy6 = 1'b0;
        repeat (2) cycle();
        tests++;
        if ({ir8, ov8, ir6, ov6} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_handshake_low: got %b expected 0000", {ir8, ov8, ir6, ov6});
        end
        reset = 1'b0;
        #1;
        tests++;
        if (snap8 !== exp8(1, 0, 8'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL reset_state8: got %h expected %h", snap8, exp8(1, 0, 8'h00, 4'd0, 0, 0));
        end
        tests++;
        if (snap6 !== exp6(1, 0, 6'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL reset_state6: got %h expected %h", snap6, exp6(1, 0, 6'h00, 4'd0, 0, 0));
        end
    endtask

    task automatic test_basic();
        beat8(3'd3, 1'b0);
        tests++;
        if (snap8 !== exp8(1, 0, 8'h08, 4'd1, 0, 0)) begin
            fails++;
            $display("FAIL basic_live_after_3: got %h expected %h", snap8, exp8(1, 0, 8'h08, 4'd1, 0, 0));
        end
        // Idle cycle with junk on idx/last must be ignored.
        idx8 = 3'd6; last8 = 1'b1;
        cycle();
        last8 = 1'b0;
        tests++;
        if (snap8 !== exp8(1, 0, 8'h08, 4'd1, 0, 0)) begin
            fails++;
            $display("FAIL basic_idle_ignored: got %h expected %h", snap8, exp8(1, 0, 8'h08, 4'd1, 0, 0));
        end
        beat8(3'd5, 1'b0);
        tests++;
        if (snap8 !== exp8(1, 0, 8'h28, 4'd2, 0, 0)) begin
            fails++;
            $display("FAIL basic_live_after_5: got %h expected %h", snap8, exp8(1, 0, 8'h28, 4'd2, 0, 0));
        end
        beat8(3'd0, 1'b1);
        tests++;
        if (snap8 !== exp8(0, 1, 8'h29, 4'd3, 0, 0)) begin
            fails++;
            $display("FAIL basic_result: got %h expected %h", snap8, exp8(0, 1, 8'h29, 4'd3, 0, 0));
        end
        handshake8();
        tests++;
        if (snap8 !== exp8(1, 0, 8'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL basic_cleared: got %h expected %h", snap8, exp8(1, 0, 8'h00, 4'd0, 0, 0));
        end
    endtask

    task automatic test_dup();
        beat8(3'd7, 1'b0);
        beat8(3'd7, 1'b1);
        tests++;
        if (snap8 !== exp8(0, 1, 8'h80, 4'd1, 1, 0)) begin
            fails++;
            $display("FAIL dup_result: got %h expected %h", snap8, exp8(0, 1, 8'h80, 4'd1, 1, 0));
        end
        handshake8();
    endtask

    task automatic test_range();
        beat6(3'd2, 1'b0);
        beat6(3'd6, 1'b1);
        tests++;
        if (snap6 !== exp6(0, 1, 6'b000100, 4'd1, 0, 1)) begin
            fails++;
            $display("FAIL range_result: got %h expected %h", snap6, exp6(0, 1, 6'b000100, 4'd1, 0, 1));
        end
        ordy6 = 1'b1;
        cycle();
        ordy6 = 1'b0;
        tests++;
        if (snap6 !== exp6(1, 0, 6'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL range_cleared: got %h expected %h", snap6, exp6(1, 0, 6'h00, 4'd0, 0, 0));
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        beat8(3'd1, 1'b0);
        beat8(3'd2, 1'b1);
        v8 = 1'b1; idx8 = 3'd4; last8 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (snap8 !== exp8(0, 1, 8'h06, 4'd2, 0, 0)) bad++;
            cycle();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_stable: got %0d unstable cycles expected 0 (last %h)", bad, snap8);
        end
        handshake8();
        tests++;
        if (snap8 !== exp8(1, 0, 8'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL backpressure_restart: got %h expected %h", snap8, exp8(1, 0, 8'h00, 4'd0, 0, 0));
        end
        cycle();
        v8 = 1'b0;
        tests++;
        if (snap8 !== exp8(1, 0, 8'h10, 4'd1, 0, 0)) begin
            fails++;
            $display("FAIL backpressure_next_set: got %h expected %h", snap8, exp8(1, 0, 8'h10, 4'd1, 0, 0));
        end
        beat8(3'd4, 1'b1);
        handshake8();
    endtask

    task automatic test_all_and_single();
        for (int i = 7; i >= 1; i--) beat8(3'(i), 1'b0);
        beat8(3'd0, 1'b1);
        tests++;
        if (snap8 !== exp8(0, 1, 8'hFF, 4'd8, 0, 0)) begin
            fails++;
            $display("FAIL all_indices: got %h expected %h", snap8, exp8(0, 1, 8'hFF, 4'd8, 0, 0));
        end
        handshake8();
        // Consumer already ready on entry to HOLD: two cycles per set.
        ordy8 = 1'b1;
        beat8(3'd4, 1'b1);
        tests++;
        if (snap8 !== exp8(0, 1, 8'h10, 4'd1, 0, 0)) begin
            fails++;
            $display("FAIL single_beat: got %h expected %h", snap8, exp8(0, 1, 8'h10, 4'd1, 0, 0));
        end
        cycle();
        ordy8 = 1'b0;
        tests++;
        if (snap8 !== exp8(1, 0, 8'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL single_fast_handshake: got %h expected %h", snap8, exp8(1, 0, 8'h00, 4'd0, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        beat8(3'd1, 1'b0);
        beat8(3'd2, 1'b0);
        tests++;
        if (snap8 !== exp8(1, 0, 8'h06, 4'd2, 0, 0)) begin
            fails++;
            $display("FAIL mid_partial: got %h expected %h", snap8, exp8(1, 0, 8'h06, 4'd2, 0, 0));
        end
        reset = 1'b1;
        v8 = 1'b1; idx8 = 3'd3; last8 = 1'b1;
        cycle();
        v8 = 1'b0; last8 = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (snap8 !== exp8(1, 0, 8'h00, 4'd0, 0, 0)) begin
            fails++;
            $display("FAIL mid_reset_clears: got %h expected %h", snap8, exp8(1, 0, 8'h00, 4'd0, 0, 0));
        end
        beat8(3'd6, 1'b1);
        tests++;
        if (snap8 !== exp8(0, 1, 8'h40, 4'd1, 0, 0)) begin
            fails++;
            $display("FAIL mid_after_reset: got %h expected %h", snap8, exp8(0, 1, 8'h40, 4'd1, 0, 0));
        end
        handshake8();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup();
        test_range();
        test_backpressure();
        test_all_and_single();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
